// File: rtl/ft2232h_pkg.sv
// Shared types and constants for the FT2232H synchronous 245 FIFO transmit path.
package ft2232h_pkg;

   localparam int unsigned FT_DATA_W = 8;

   // FT2232H control pins are active-low
   localparam logic WR_ACTIVE   = 1'b0;
   localparam logic WR_IDLE     = 1'b1;
   localparam logic SIWU_ACTIVE = 1'b0;
   localparam logic SIWU_IDLE   = 1'b1;
   localparam logic TXE_READY   = 1'b0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      WAIT = 2'd2,
      SIWU = 2'd3
   } state_t;

endpackage

// File: rtl/ft2232h_tx_fifo.sv
// Single-clock show-ahead FIFO; head_o is the entry under the registered read pointer.
module ft2232h_tx_fifo
   import ft2232h_pkg::*;
#(
   parameter int unsigned DEPTH_LOG2 = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  push_i,
   input  logic                  pop_i,
   input  logic [FT_DATA_W-1:0]  din_i,
   output logic [FT_DATA_W-1:0]  head_o,
   output logic                  full_o,
   output logic                  empty_o,
   output logic [DEPTH_LOG2:0]   level_o
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam int unsigned PTR_W = DEPTH_LOG2 + 1;

   logic [FT_DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]     wr_ptr, rd_ptr, wr_nxt, rd_nxt;

   always_comb begin
      wr_nxt = push_i ? wr_ptr + PTR_W'(1) : wr_ptr;
      rd_nxt = pop_i  ? rd_ptr + PTR_W'(1) : rd_ptr;
   end

   // Flags are computed from the next pointers so they are registered outputs
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         full_o  <= 1'b0;
         empty_o <= 1'b1;
         level_o <= '0;
      end else begin
         wr_ptr  <= wr_nxt;
         rd_ptr  <= rd_nxt;
         full_o  <= (wr_nxt[DEPTH_LOG2] != rd_nxt[DEPTH_LOG2]) &&
                    (wr_nxt[DEPTH_LOG2-1:0] == rd_nxt[DEPTH_LOG2-1:0]);
         empty_o <= (wr_nxt == rd_nxt);
         level_o <= wr_nxt - rd_nxt;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_i) mem[wr_ptr[DEPTH_LOG2-1:0]] <= din_i;
   end

   assign head_o = empty_o ? '0 : mem[rd_ptr[DEPTH_LOG2-1:0]];

endmodule

// File: rtl/ft2232h_tx.sv
// FT2232H sync-245 transmit engine: stream in, FIFO, WR#/TXE# handshake out.
// Optional FT_TX_SIWU_EN adds a flush request that pulses SIWU# once the FIFO drains.
module ft2232h_tx
   import ft2232h_pkg::*;
#(
   parameter int unsigned DEPTH_LOG2 = 4,
   parameter int unsigned CNT_W      = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [FT_DATA_W-1:0]  din_i,
   input  logic                  din_valid_i,
   output logic                  din_ready_o,
   output logic [FT_DATA_W-1:0]  data_o,
   output logic                  wr_n_o,
   input  logic                  txe_n_i,
   input  logic                  flush_i,
   output logic                  siwu_n_o,
   output logic [DEPTH_LOG2:0]   level_o,
   output logic                  busy_o,
   output logic [CNT_W-1:0]      byte_count_o,
   output logic                  overflow_o
);

   localparam int unsigned LVL_W = DEPTH_LOG2 + 1;

   logic             full, empty, push, pop;
   logic [LVL_W-1:0] post_pop, level_nxt;
   state_t           state, state_nxt;

   ft2232h_tx_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push),
      .pop_i   (pop),
      .din_i   (din_i),
      .head_o  (data_o),
      .full_o  (full),
      .empty_o (empty),
      .level_o (level_o)
   );

   assign din_ready_o = !full;
   assign push        = din_valid_i && !full;
   assign pop         = (wr_n_o == WR_ACTIVE) && (txe_n_i == TXE_READY) && !empty;

`ifdef FT_TX_SIWU_EN
   logic flush_pend;

   // Pending flush survives until the SIWU pulse has been issued
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) flush_pend <= 1'b0;
      else       flush_pend <= flush_i || (flush_pend && (state != SIWU));
   end
`else
   logic unused_flush;
   assign unused_flush = flush_i;
`endif

   // Transitions use occupancy after this edge's pop, excluding this edge's push
   always_comb begin
      post_pop  = level_o - LVL_W'(pop);
      level_nxt = post_pop + LVL_W'(push);
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (post_pop != '0) state_nxt = (txe_n_i == TXE_READY) ? SEND : WAIT;
`ifdef FT_TX_SIWU_EN
            else if (flush_pend) state_nxt = SIWU;
`endif
         end
         SEND: begin
            if (post_pop == '0)              state_nxt = IDLE;
            else if (txe_n_i != TXE_READY)   state_nxt = WAIT;
            else                             state_nxt = SEND;
         end
         WAIT: begin
            if (txe_n_i == TXE_READY) state_nxt = SEND;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state        <= IDLE;
         wr_n_o       <= WR_IDLE;
         siwu_n_o     <= SIWU_IDLE;
         busy_o       <= 1'b0;
         byte_count_o <= '0;
         overflow_o   <= 1'b0;
      end else begin
         state  <= state_nxt;
         wr_n_o <= (state_nxt == SEND) ? WR_ACTIVE : WR_IDLE;
`ifdef FT_TX_SIWU_EN
         siwu_n_o <= (state_nxt == SIWU) ? SIWU_ACTIVE : SIWU_IDLE;
`else
         siwu_n_o <= SIWU_IDLE;
`endif
         busy_o <= (level_nxt != '0) || (state_nxt != IDLE);
         if (pop)                 byte_count_o <= byte_count_o + CNT_W'(1);
         if (din_valid_i && full) overflow_o   <= 1'b1;
      end
   end

endmodule
